// File: rtl/calc_pkg.sv
// ============================================================================
// Module   : calc_pkg
// Brief    : FSM states, chord opcodes and chord encoder for calc_cmd_enc.
// Revision : 1.0
// ============================================================================
`default_nettype none

package calc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATHER = 2'd1,
        EMIT   = 2'd2,
        HOLD   = 2'd3
    } calc_state_t;

    // Opcodes indexed by the {l,c,r} chord
    localparam logic [3:0] c_op_r   = 4'b0001;
    localparam logic [3:0] c_op_c   = 4'b0010;
    localparam logic [3:0] c_op_cr  = 4'b0110;
    localparam logic [3:0] c_op_l   = 4'b0100;
    localparam logic [3:0] c_op_lr  = 4'b1001;
    localparam logic [3:0] c_op_lc  = 4'b1010;
    localparam logic [3:0] c_op_lcr = 4'b0101;

    function automatic logic [3:0] encode(input logic [2:0] chord);
        logic [3:0] op;
        op = 4'b0000;
        case (chord)
            3'b001:  op = c_op_r;
            3'b010:  op = c_op_c;
            3'b011:  op = c_op_cr;
            3'b100:  op = c_op_l;
            3'b101:  op = c_op_lr;
            3'b110:  op = c_op_lc;
            3'b111:  op = c_op_lcr;
            default: op = 4'b0000;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/calc_debounce.sv
// ============================================================================
// Module   : calc_debounce
// Brief    : Input synchroniser followed by a consecutive-cycle debouncer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module calc_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int              CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   c_last = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign level  = r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
        end
    end

    // Level flips on the Nth consecutive differing cycle; any agreement restarts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (w_sync == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt   <= '0;
            r_level <= w_sync;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/calc_cmd_enc.sv
// ============================================================================
// Module   : calc_cmd_enc
// Brief    : Turns debounced push-button chords into one-cycle ALU opcode
//            strobes. Define CALC_CMD_AUTOREPEAT_EN to add auto-repeat in HOLD.
// Revision : 1.0
// ============================================================================
`default_nettype none

module calc_cmd_enc
    import calc_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CHORD_WINDOW    = 8,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btnl,
    input  logic       btnc,
    input  logic       btnr,
    output logic [3:0] alu_op,
    output logic       op_valid,
    output logic       busy
);

    localparam int            WCW        = $clog2(CHORD_WINDOW + 1);
    localparam logic [WCW-1:0] c_win_last = WCW'(CHORD_WINDOW - 1);
    localparam logic [WCW-1:0] c_win_max  = WCW'(CHORD_WINDOW);

    logic [2:0]     w_raw;
    logic [2:0]     w_deb;
    logic           w_any;

    calc_state_t    r_state, w_state_nxt;
    logic [2:0]     r_chord, w_chord_nxt;
    logic [WCW-1:0] r_win,   w_win_nxt;
    logic [3:0]     r_op,    w_op_nxt;
    logic           r_valid, w_valid_nxt;

    assign w_raw = {btnl, btnc, btnr};

    generate
        for (genvar i = 0; i < 3; i++) begin : g_btn
            calc_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk   (clk),
                .rst_n (rst_n),
                .raw   (w_raw[i]),
                .level (w_deb[i])
            );
        end
    endgenerate

    assign w_any = |w_deb;

`ifdef CALC_CMD_AUTOREPEAT_EN
    localparam int             RCW        = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RCW-1:0] c_rep_last = RCW'(REPEAT_CYCLES - 1);
    localparam logic [RCW-1:0] c_rep_max  = RCW'(REPEAT_CYCLES);

    logic [RCW-1:0] r_rep, w_rep_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep <= '0;
        end else begin
            r_rep <= w_rep_nxt;
        end
    end
`else
    generate
        if (REPEAT_CYCLES < 1) begin : g_repeat_cfg_invalid
        end
    endgenerate
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_chord <= '0;
            r_win   <= '0;
            r_op    <= 4'b0000;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_chord <= w_chord_nxt;
            r_win   <= w_win_nxt;
            r_op    <= w_op_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // op_valid is registered so it shares the EMIT cycle with the new alu_op
    always_comb begin
        w_state_nxt = r_state;
        w_chord_nxt = r_chord;
        w_win_nxt   = r_win;
        w_op_nxt    = r_op;
        w_valid_nxt = 1'b0;
`ifdef CALC_CMD_AUTOREPEAT_EN
        w_rep_nxt   = r_rep;
`endif
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = GATHER;
                    w_chord_nxt = w_deb;
                    w_win_nxt   = '0;
                end
            end
            GATHER: begin
                w_chord_nxt = r_chord | w_deb;
                if (!w_any) begin
                    w_state_nxt = IDLE;
                    w_chord_nxt = '0;
                    w_win_nxt   = '0;
                end else if (r_win == c_win_last) begin
                    w_state_nxt = EMIT;
                    w_op_nxt    = encode(w_chord_nxt);
                    w_valid_nxt = 1'b1;
                    w_win_nxt   = c_win_max;
`ifdef CALC_CMD_AUTOREPEAT_EN
                    w_rep_nxt   = '0;
`endif
                end else if (r_win != c_win_max) begin
                    w_win_nxt   = r_win + 1'b1;
                end
            end
            EMIT: begin
                w_state_nxt = HOLD;
`ifdef CALC_CMD_AUTOREPEAT_EN
                w_rep_nxt   = (r_rep != c_rep_max) ? r_rep + 1'b1 : r_rep;
`endif
            end
            HOLD: begin
                if (!w_any) begin
                    w_state_nxt = IDLE;
                    w_chord_nxt = '0;
                    w_win_nxt   = '0;
`ifdef CALC_CMD_AUTOREPEAT_EN
                    w_rep_nxt   = '0;
                end else if (r_rep == c_rep_last) begin
                    w_valid_nxt = 1'b1;
                    w_rep_nxt   = '0;
                end else if (r_rep != c_rep_max) begin
                    w_rep_nxt   = r_rep + 1'b1;
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign alu_op   = r_op;
    assign op_valid = r_valid;
    assign busy     = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_calc_cmd_enc.sv
// ============================================================================
// Module   : tb_calc_cmd_enc
// Brief    : Directed table-driven bench for calc_cmd_enc.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_calc_cmd_enc;

    localparam int DEB = 4;
    localparam int WIN = 8;
    localparam int REP = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       btnl  = 1'b0;
    logic       btnc  = 1'b0;
    logic       btnr  = 1'b0;
    logic [3:0] alu_op;
    logic       op_valid;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int strobes[$];

    typedef struct {
        logic [2:0] btns;
        int         hold;
        logic [3:0] exp_op;
        int         exp_strobes;
    } vec_t;

    vec_t vecs[7];

    calc_cmd_enc #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (DEB),
        .CHORD_WINDOW    (WIN),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btnl     (btnl),
        .btnc     (btnc),
        .btnr     (btnr),
        .alu_op   (alu_op),
        .op_valid (op_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (op_valid === 1'b1) strobes.push_back(cyc);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_btns(input logic [2:0] b);
        {btnl, btnc, btnr} = b;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_busy(input logic v, input int limit, input string name);
        int k;
        k = 0;
        while (busy !== v && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, busy}, {31'd0, v});
    endtask

    task automatic wait_strobe(input int limit, input string name);
        int k;
        k = 0;
        while (strobes.size() == 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(name, (strobes.size() > 0) ? 1 : 0, 1);
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        strobes.delete();
        @(negedge clk);
        set_btns(v.btns);
        wait_cycles(v.hold);
        set_btns(3'b000);
        wait_cycles(25);
        check($sformatf("vec%0d_strobes", idx), strobes.size(), v.exp_strobes);
        check($sformatf("vec%0d_alu_op", idx), {28'd0, alu_op}, {28'd0, v.exp_op});
        check($sformatf("vec%0d_busy", idx), {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int exp_n;

        vecs[0] = '{3'b001, 20, 4'b0001, 1};
        vecs[1] = '{3'b010, 20, 4'b0010, 1};
        vecs[2] = '{3'b011, 20, 4'b0110, 1};
        vecs[3] = '{3'b100, 20, 4'b0100, 1};
        vecs[4] = '{3'b101, 20, 4'b1001, 1};
        vecs[5] = '{3'b110, 20, 4'b1010, 1};
        vecs[6] = '{3'b111, 20, 4'b0101, 1};

        // Reset values
        wait_cycles(3);
        check("reset_alu_op", {28'd0, alu_op}, 32'd0);
        check("reset_op_valid", {31'd0, op_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Bouncing btnc never debounces
        strobes.delete();
        for (int i = 0; i < 10; i++) begin
            btnc = ~btnc;
            wait_cycles(2);
        end
        btnc = 1'b0;
        wait_cycles(20);
        check("bounce_strobes", strobes.size(), 0);
        check("bounce_alu_op", {28'd0, alu_op}, 32'd0);
        check("bounce_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 7; i++) run_vector(vecs[i], i);

        // btnl first, btnr joins three cycles later inside the window
        strobes.delete();
        set_btns(3'b100);
        wait_cycles(3);
        set_btns(3'b101);
        wait_cycles(17);
        set_btns(3'b000);
        wait_cycles(25);
        check("late_add_strobes", strobes.size(), 1);
        check("late_add_alu_op", {28'd0, alu_op}, 32'h9);

        // btnr held 50 cycles
        strobes.delete();
        set_btns(3'b001);
        wait_cycles(50);
        set_btns(3'b000);
        wait_cycles(25);
`ifdef CALC_CMD_AUTOREPEAT_EN
        exp_n = 3;
`else
        exp_n = 1;
`endif
        check("long_r_strobes", strobes.size(), exp_n);
        check("long_r_alu_op", {28'd0, alu_op}, 32'h1);
        check("long_r_busy", {31'd0, busy}, 32'd0);

        // btnc debounced high for only 5 cycles: abandoned in GATHER
        strobes.delete();
        set_btns(3'b010);
        wait_cycles(5);
        set_btns(3'b000);
        wait_busy(1'b1, 10, "short_c_busy_rise");
        wait_busy(1'b0, 20, "short_c_busy_fall");
        wait_cycles(10);
        check("short_c_strobes", strobes.size(), 0);
        check("short_c_alu_op", {28'd0, alu_op}, 32'h1);

        // All three held, async reset in HOLD, still held after release of reset
        strobes.delete();
        set_btns(3'b111);
        wait_strobe(40, "all_first_strobe");
        check("all_alu_op", {28'd0, alu_op}, 32'h5);
        wait_cycles(5);
        check("all_busy_hold", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_alu_op", {28'd0, alu_op}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_op_valid", {31'd0, op_valid}, 32'd0);
        @(negedge clk);
        strobes.delete();
        rst_n = 1'b1;
        wait_strobe(40, "repress_strobe");
        check("repress_alu_op", {28'd0, alu_op}, 32'h5);
        set_btns(3'b000);
        wait_cycles(25);
        check("repress_strobes", strobes.size(), 1);
        check("repress_busy", {31'd0, busy}, 32'd0);

        // Reset during GATHER aborts without a strobe
        strobes.delete();
        set_btns(3'b001);
        wait_busy(1'b1, 15, "gather_rst_busy");
        wait_cycles(2);
        #2 rst_n = 1'b0;
        #1 check("gather_rst_busy_low", {31'd0, busy}, 32'd0);
        set_btns(3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(30);
        check("gather_rst_strobes", strobes.size(), 0);
        check("gather_rst_alu_op", {28'd0, alu_op}, 32'd0);

        // btnc held well past EMIT: auto-repeat cadence when compiled in
        strobes.delete();
        set_btns(3'b010);
        wait_strobe(40, "repeat_first_strobe");
        wait_cycles(54);
        set_btns(3'b000);
        wait_cycles(25);
`ifdef CALC_CMD_AUTOREPEAT_EN
        exp_n = 4;
`else
        exp_n = 1;
`endif
        check("repeat_strobes", strobes.size(), exp_n);
        check("repeat_alu_op", {28'd0, alu_op}, 32'h2);
`ifdef CALC_CMD_AUTOREPEAT_EN
        if (strobes.size() >= 4) begin
            for (int i = 1; i < 4; i++)
                check($sformatf("repeat_offset%0d", i), strobes[i] - strobes[0], REP * i);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
